// File: rtl/ml_layer_sequencer_if.sv
// Control, RAM-read and output-write bundle between the layer sequencer and the ML register block.
// Latency: none; wires only. RAM read data is expected one cycle after rd_en.
// Backpressure: none; the register block must accept every out_we and answer every rd_en.
interface ml_layer_sequencer_if #(
  parameter int pINPUTCNT   = 4,
  parameter int pOUTPUTCNT  = 4,
  parameter int pWEIGHTCNT  = 16,
  parameter int pDATA_WIDTH = 8
);
  localparam int W_AW = (pWEIGHTCNT > 1) ? $clog2(pWEIGHTCNT) : 1;
  localparam int I_AW = (pINPUTCNT  > 1) ? $clog2(pINPUTCNT)  : 1;
  localparam int O_AW = (pOUTPUTCNT > 1) ? $clog2(pOUTPUTCNT) : 1;

  // control / status
  logic start;
  logic abort;
  logic relu_en;
  logic busy;
  logic done;
  logic sat_flag;
  logic tio_trigger;

  // synchronous-read RAM port (shared strobe)
  logic                          rd_en;
  logic [W_AW-1:0]               w_addr;
  logic [I_AW-1:0]               in_addr;
  logic [O_AW-1:0]               b_addr;
  logic signed [pDATA_WIDTH-1:0] w_data;
  logic signed [pDATA_WIDTH-1:0] in_data;
  logic signed [pDATA_WIDTH-1:0] b_data;

  // output storage write port
  logic                          out_we;
  logic [O_AW-1:0]               out_addr;
  logic signed [pDATA_WIDTH-1:0] out_data;

  // sequencer side
  modport master (
    input  start, abort, relu_en, w_data, in_data, b_data,
    output busy, done, sat_flag, tio_trigger, rd_en, w_addr, in_addr, b_addr,
           out_we, out_addr, out_data
  );

  // register block side
  modport slave (
    output start, abort, relu_en, w_data, in_data, b_data,
    input  busy, done, sat_flag, tio_trigger, rd_en, w_addr, in_addr, b_addr,
           out_we, out_addr, out_data
  );
endinterface

// File: rtl/ml_layer_sequencer.sv
// Sequences one fully-connected layer: out[j] = act(bias[j] + sum_i w[j*N+i]*in[i]), one MAC per cycle.
// Latency: neuron j written at T0+1+j*(N+2)+(N+1), done at T0+1+M*(N+2) after start is accepted at edge T0.
// Backpressure: none; RAMs answer one cycle after rd_en, output storage takes every out_we; abort stops at once.
module ml_layer_sequencer #(
  parameter int pINPUTCNT   = 4,
  parameter int pOUTPUTCNT  = 4,
  parameter int pWEIGHTCNT  = 16,
  parameter int pDATA_WIDTH = 8,
  parameter int pACC_WIDTH  = 24,
  parameter int pSHIFT      = 0
) (
  input logic               usb_clk,
  input logic               resetn,
  ml_layer_sequencer_if.master bus
);

  localparam int W_AW = (pWEIGHTCNT > 1) ? $clog2(pWEIGHTCNT) : 1;
  localparam int I_AW = (pINPUTCNT  > 1) ? $clog2(pINPUTCNT)  : 1;
  localparam int O_AW = (pOUTPUTCNT > 1) ? $clog2(pOUTPUTCNT) : 1;
  localparam int P_W  = 2 * pDATA_WIDTH;
  localparam int MAXI = (1 <<< (pDATA_WIDTH - 1)) - 1;
  localparam int MINI = -(1 <<< (pDATA_WIDTH - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [I_AW-1:0] r_i;
  logic [O_AW-1:0] r_j;
  logic [W_AW-1:0] r_waddr;       // running j*N+i, avoids a multiplier
  logic            r_relu;
  logic            r_sat;
  logic            r_rd_d;        // read data is valid this cycle
  logic            r_first_d;     // ... and it is the first beat of a neuron
  logic signed [pACC_WIDTH-1:0] r_acc;

  logic w_accept;
  logic w_last_i;
  logic w_last_j;
  logic w_in_issue;
  logic w_in_write;
  logic w_busy;

  logic signed [P_W-1:0]         w_prod;
  logic signed [pACC_WIDTH-1:0]  w_prod_ext;
  logic signed [pACC_WIDTH-1:0]  w_bias_ext;
  logic signed [pACC_WIDTH-1:0]  w_sum;
  logic signed [pACC_WIDTH-1:0]  w_shifted;
  logic signed [pACC_WIDTH-1:0]  w_hi;
  logic signed [pACC_WIDTH-1:0]  w_lo;
  logic signed [pDATA_WIDTH-1:0] w_result;
  logic                          w_clamped;

  assign w_accept   = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_last_i   = (r_i == I_AW'(pINPUTCNT - 1));
  assign w_last_j   = (r_j == O_AW'(pOUTPUTCNT - 1));
  assign w_in_issue = (r_state == S_ISSUE);
  assign w_in_write = (r_state == S_WRITE);
  assign w_busy     = (r_state == S_ISSUE) || (r_state == S_DRAIN) || (r_state == S_WRITE);

  // Full-precision product and sign-extended operands for the accumulator.
  assign w_prod     = P_W'(bus.w_data) * P_W'(bus.in_data);
  assign w_prod_ext = pACC_WIDTH'(w_prod);
  assign w_bias_ext = pACC_WIDTH'(bus.b_data);
  assign w_sum      = (r_first_d ? w_bias_ext : r_acc) + w_prod_ext;

  // Scale and clamp bounds; ReLU simply raises the lower bound to zero.
  assign w_shifted = r_acc >>> pSHIFT;
  assign w_hi      = pACC_WIDTH'(MAXI);
  assign w_lo      = r_relu ? '0 : pACC_WIDTH'(MINI);

  // Saturate the scaled accumulator into the output width and flag any change.
  always_comb begin
    w_result  = w_shifted[pDATA_WIDTH-1:0];
    w_clamped = 1'b0;
    if (w_shifted > w_hi) begin
      w_result  = pDATA_WIDTH'(MAXI);
      w_clamped = 1'b1;
    end else if (w_shifted < w_lo) begin
      w_result  = r_relu ? '0 : pDATA_WIDTH'(MINI);
      w_clamped = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge usb_clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs; abort from any active state lands in IDLE next cycle.
  always_comb begin
    w_next          = r_state;
    bus.busy        = w_busy;
    bus.tio_trigger = w_busy;
    bus.sat_flag    = r_sat;
    bus.rd_en       = 1'b0;
    bus.w_addr      = '0;
    bus.in_addr     = '0;
    bus.b_addr      = '0;
    bus.out_we      = 1'b0;
    bus.out_addr    = '0;
    bus.out_data    = '0;
    bus.done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        bus.rd_en   = 1'b1;
        bus.w_addr  = r_waddr;
        bus.in_addr = r_i;
        bus.b_addr  = r_j;
        if (bus.abort)     w_next = S_IDLE;
        else if (w_last_i) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_next = bus.abort ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        // gated by resetn so a reset landing on a write cycle never commits it
        bus.out_we   = resetn;
        bus.out_addr = r_j;
        bus.out_data = w_result;
        if (bus.abort)     w_next = S_IDLE;
        else if (w_last_j) w_next = S_DONE;
        else               w_next = S_ISSUE;
      end
      S_DONE: begin
        bus.done = resetn;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counters, read pipeline, accumulator and sticky saturation flag.
  always_ff @(posedge usb_clk) begin
    if (!resetn) begin
      r_i       <= '0;
      r_j       <= '0;
      r_waddr   <= '0;
      r_relu    <= 1'b0;
      r_sat     <= 1'b0;
      r_rd_d    <= 1'b0;
      r_first_d <= 1'b0;
      r_acc     <= '0;
    end else begin
      // a read issued in the abort cycle is dropped so it cannot touch the accumulator
      r_rd_d    <= w_in_issue && !bus.abort;
      r_first_d <= w_in_issue && (r_i == '0);
      if (r_rd_d) begin
        r_acc <= w_sum;
      end
      if (w_accept) begin
        r_relu  <= bus.relu_en;
        r_sat   <= 1'b0;
        r_i     <= '0;
        r_j     <= '0;
        r_waddr <= '0;
      end
      if (w_in_issue) begin
        r_i     <= w_last_i ? '0 : r_i + 1'b1;
        r_waddr <= r_waddr + 1'b1;
      end
      if (w_in_write) begin
        if (w_clamped) r_sat <= 1'b1;
        if (!w_last_j) r_j <= r_j + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ml_layer_sequencer.sv
// Directed bench for ml_layer_sequencer at default parameters (N=4, M=4).
// Cycle c of a run is the clock period that ends with edge T0+c; start is sampled at edge T0.
// Outputs are sampled on the falling edge, inputs driven right after sampling.
module tb_ml_layer_sequencer;
  localparam int N  = 4;
  localparam int M  = 4;
  localparam int WC = 16;
  localparam int DW = 8;

  logic usb_clk = 1'b0;
  logic resetn  = 1'b0;
  always #5 usb_clk = ~usb_clk;

  ml_layer_sequencer_if #(.pINPUTCNT(N), .pOUTPUTCNT(M), .pWEIGHTCNT(WC), .pDATA_WIDTH(DW)) bus ();

  ml_layer_sequencer #(
    .pINPUTCNT(N), .pOUTPUTCNT(M), .pWEIGHTCNT(WC),
    .pDATA_WIDTH(DW), .pACC_WIDTH(24), .pSHIFT(0)
  ) dut (
    .usb_clk (usb_clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  // synchronous-read RAM models
  logic signed [DW-1:0] w_mem  [WC];
  logic signed [DW-1:0] in_mem [N];
  logic signed [DW-1:0] b_mem  [M];
  always @(posedge usb_clk) begin
    if (bus.rd_en) begin
      bus.w_data  <= w_mem[bus.w_addr];
      bus.in_data <= in_mem[bus.in_addr];
      bus.b_data  <= b_mem[bus.b_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  // observations of the last run
  int         wr_cnt, done_cnt, done_cyc, rd_cnt, tio_err;
  int         wr_cyc  [8];
  logic [1:0] wr_addr [8];
  logic [7:0] wr_dat  [8];
  logic       busy_log [64];
  logic [23:0] snap;
  logic       sat_end;

  task automatic load_identity();
    for (int j = 0; j < M; j++)
      for (int i = 0; i < N; i++)
        w_mem[j*N+i] = (i == j) ? 8'sd1 : 8'sd0;
    for (int i = 0; i < N; i++) in_mem[i] = 8'(i + 1);
    for (int j = 0; j < M; j++) b_mem[j] = 8'sd0;
  endtask

  task automatic load_ones_neg();
    for (int k = 0; k < WC; k++) w_mem[k] = 8'sd1;
    for (int i = 0; i < N; i++) in_mem[i] = 8'(-(i + 1));
    for (int j = 0; j < M; j++) b_mem[j] = 8'(j * 5);
  endtask

  task automatic load_sat(input bit neg);
    for (int k = 0; k < WC; k++) w_mem[k] = 8'sd127;
    for (int i = 0; i < N; i++) in_mem[i] = neg ? -8'sd128 : 8'sd127;
    for (int j = 0; j < M; j++) b_mem[j] = 8'sd127;
  endtask

  // Start one layer and observe ncyc cycles; abort/reset/extra start at the given cycles (-1 = never).
  task automatic run_layer(input logic relu, input int abort_c, input int rst_c,
                           input int s1, input int s2, input int ncyc);
    wr_cnt = 0; done_cnt = 0; done_cyc = -1; rd_cnt = 0; tio_err = 0; snap = '1;
    for (int k = 0; k < 64; k++) busy_log[k] = 1'b0;
    @(negedge usb_clk);
    bus.relu_en = relu;
    bus.start   = 1'b1;
    bus.abort   = 1'b0;
    @(posedge usb_clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge usb_clk);
      if (bus.out_we === 1'b1) begin
        if (wr_cnt < 8) begin
          wr_cyc[wr_cnt]  = c;
          wr_addr[wr_cnt] = bus.out_addr;
          wr_dat[wr_cnt]  = bus.out_data;
        end
        wr_cnt++;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (bus.rd_en === 1'b1) rd_cnt++;
      if (bus.tio_trigger !== bus.busy) tio_err++;
      busy_log[c] = bus.busy;
      if (c == rst_c + 1)
        snap = {bus.busy, bus.done, bus.sat_flag, bus.tio_trigger, bus.rd_en, bus.w_addr,
                bus.in_addr, bus.b_addr, bus.out_we, bus.out_addr, bus.out_data};
      bus.start = (c == s1) || (c == s2);
      bus.abort = (c == abort_c);
      resetn    = (c != rst_c);
    end
    sat_end   = bus.sat_flag;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    resetn    = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge usb_clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.tio_trigger !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b/%b expected 0/0", bus.busy, bus.tio_trigger);
    end
    tests++;
    if (bus.sat_flag !== 1'b0 || bus.done !== 1'b0) begin
      fails++; $display("FAIL reset_flags: sat=%b done=%b expected 0", bus.sat_flag, bus.done);
    end
    tests++;
    if (bus.rd_en !== 1'b0 || bus.out_we !== 1'b0 || bus.out_data !== 8'h00) begin
      fails++; $display("FAIL reset_ports: rd_en=%b out_we=%b out_data=%h expected 0", bus.rd_en, bus.out_we, bus.out_data);
    end
    resetn = 1'b1;
    @(negedge usb_clk);
  endtask

  task automatic test_identity();
    load_identity();
    run_layer(1'b1, -1, -1, -1, -1, 28);
    tests++;
    if (wr_cnt !== 4) begin fails++; $display("FAIL ident_wr_cnt: got %0d expected 4", wr_cnt); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (wr_cyc[k] !== 6*(k+1) || wr_addr[k] !== 2'(k) || wr_dat[k] !== 8'(k+1)) begin
        fails++;
        $display("FAIL ident_out%0d: got cyc=%0d addr=%0d data=%0d expected cyc=%0d addr=%0d data=%0d",
                 k, wr_cyc[k], wr_addr[k], wr_dat[k], 6*(k+1), k, k+1);
      end
    end
    tests++;
    if (done_cnt !== 1 || done_cyc !== 25) begin
      fails++; $display("FAIL ident_done: got count=%0d cyc=%0d expected 1/25", done_cnt, done_cyc);
    end
    tests++;
    if (busy_log[1] !== 1'b1 || busy_log[24] !== 1'b1 || busy_log[25] !== 1'b0) begin
      fails++; $display("FAIL ident_busy: got c1=%b c24=%b c25=%b expected 1/1/0", busy_log[1], busy_log[24], busy_log[25]);
    end
    tests++;
    if (rd_cnt !== 16 || tio_err !== 0 || sat_end !== 1'b0) begin
      fails++; $display("FAIL ident_misc: got rd=%0d tio_err=%0d sat=%b expected 16/0/0", rd_cnt, tio_err, sat_end);
    end
  endtask

  task automatic test_bias_neg();
    logic [7:0] e_lin  [4];
    logic [7:0] e_relu [4];
    e_lin  = '{8'hF6, 8'hFB, 8'h00, 8'h05};
    e_relu = '{8'h00, 8'h00, 8'h00, 8'h05};
    load_ones_neg();
    run_layer(1'b0, -1, -1, -1, -1, 26);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (wr_dat[k] !== e_lin[k]) begin
        fails++; $display("FAIL bias_lin%0d: got %h expected %h", k, wr_dat[k], e_lin[k]);
      end
    end
    tests++;
    if (sat_end !== 1'b0 || wr_cnt !== 4) begin
      fails++; $display("FAIL bias_lin_sat: got sat=%b wr=%0d expected 0/4", sat_end, wr_cnt);
    end
    run_layer(1'b1, -1, -1, -1, -1, 26);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (wr_dat[k] !== e_relu[k]) begin
        fails++; $display("FAIL bias_relu%0d: got %h expected %h", k, wr_dat[k], e_relu[k]);
      end
    end
    tests++;
    if (sat_end !== 1'b1) begin fails++; $display("FAIL bias_relu_sat: got %b expected 1", sat_end); end
  endtask

  task automatic test_saturation();
    load_sat(1'b0);
    run_layer(1'b1, -1, -1, -1, -1, 26);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (wr_dat[k] !== 8'h7F) begin fails++; $display("FAIL sat_pos%0d: got %h expected 7f", k, wr_dat[k]); end
    end
    tests++;
    if (sat_end !== 1'b1) begin fails++; $display("FAIL sat_pos_flag: got %b expected 1", sat_end); end
    load_sat(1'b1);
    run_layer(1'b0, -1, -1, -1, -1, 26);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (wr_dat[k] !== 8'h80) begin fails++; $display("FAIL sat_neg%0d: got %h expected 80", k, wr_dat[k]); end
    end
    tests++;
    if (sat_end !== 1'b1) begin fails++; $display("FAIL sat_neg_flag: got %b expected 1", sat_end); end
  endtask

  task automatic test_abort();
    load_sat(1'b0);
    run_layer(1'b1, 14, -1, -1, -1, 28);
    tests++;
    if (wr_cnt !== 2 || wr_cyc[0] !== 6 || wr_cyc[1] !== 12) begin
      fails++; $display("FAIL abort_writes: got n=%0d c0=%0d c1=%0d expected 2/6/12", wr_cnt, wr_cyc[0], wr_cyc[1]);
    end
    tests++;
    if (done_cnt !== 0) begin fails++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
    tests++;
    if (busy_log[14] !== 1'b1 || busy_log[15] !== 1'b0 || rd_cnt !== 10) begin
      fails++; $display("FAIL abort_busy: got c14=%b c15=%b rd=%0d expected 1/0/10", busy_log[14], busy_log[15], rd_cnt);
    end
    tests++;
    if (sat_end !== 1'b1) begin fails++; $display("FAIL abort_sat_hold: got %b expected 1", sat_end); end
    load_identity();
    run_layer(1'b1, -1, -1, -1, -1, 27);
    tests++;
    if (wr_cnt !== 4 || done_cyc !== 25 || wr_dat[3] !== 8'h04 || sat_end !== 1'b0) begin
      fails++; $display("FAIL abort_rerun: got wr=%0d done=%0d d3=%h sat=%b expected 4/25/04/0", wr_cnt, done_cyc, wr_dat[3], sat_end);
    end
  endtask

  task automatic test_reset_mid();
    load_sat(1'b0);
    run_layer(1'b1, -1, 8, -1, -1, 28);
    tests++;
    if (wr_cnt !== 1 || done_cnt !== 0) begin
      fails++; $display("FAIL rstmid_writes: got wr=%0d done=%0d expected 1/0", wr_cnt, done_cnt);
    end
    tests++;
    if (snap !== 24'h0) begin fails++; $display("FAIL rstmid_outputs: got %h expected 000000", snap); end
    load_identity();
    run_layer(1'b1, -1, -1, -1, -1, 27);
    tests++;
    if (wr_cnt !== 4 || done_cyc !== 25 || wr_cyc[0] !== 6 || wr_dat[2] !== 8'h03) begin
      fails++; $display("FAIL rstmid_rerun: got wr=%0d done=%0d c0=%0d d2=%h expected 4/25/6/03", wr_cnt, done_cyc, wr_cyc[0], wr_dat[2]);
    end
  endtask

  task automatic test_start_while_busy();
    load_identity();
    run_layer(1'b1, -1, -1, 3, 20, 30);
    tests++;
    if (wr_cnt !== 4 || wr_cyc[3] !== 24 || done_cnt !== 1 || done_cyc !== 25) begin
      fails++; $display("FAIL busy_start: got wr=%0d c3=%0d done=%0d@%0d expected 4/24/1@25", wr_cnt, wr_cyc[3], done_cnt, done_cyc);
    end
  endtask

  task automatic test_start_abort_idle();
    int busy_seen;
    busy_seen = 0;
    @(negedge usb_clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge usb_clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) busy_seen++;
      @(negedge usb_clk);
    end
    tests++;
    if (busy_seen !== 0) begin fails++; $display("FAIL start_abort_idle: got %0d busy cycles expected 0", busy_seen); end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.relu_en = 1'b0;
    test_reset();
    test_identity();
    test_bias_neg();
    test_saturation();
    test_abort();
    test_reset_mid();
    test_start_while_busy();
    test_start_abort_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
